hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central stall/bubble controller for the 5-stage pipeline (F/D/E/M/W).
//  Compares D-stage source-register demand (Tuse) against in-flight producers in
//  E and M (Tnew) and generates PC/IF-ID hold and ID-EX bubble.
//  Owns the mult/div busy timer and holds D-stage HI/LO instructions while the
//  unit is busy. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu issue
//  DIV_CYCLES   10  busy cycles after a div/divu issue
//  CNT_W        4   md timer width; must satisfy 2**CNT_W > max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high
//  d_rs         in   5   D-stage rs address
//  d_rt         in   5   D-stage rt address
//  d_tuse_rs    in   2   cycles until rs is consumed (0..2; 3 = rs not used)
//  d_tuse_rt    in   2   cycles until rt is consumed (0..2; 3 = rt not used)
//  d_md_use     in   1   D instr is mfhi/mflo/mthi/mtlo/mult/div class
//  e_regaddr    in   5   E-stage destination register
//  e_regwrite   in   1   E-stage writes the GPR file
//  e_tnew       in   2   E-stage cycles until result is available (0..2)
//  m_regaddr    in   5   M-stage destination register
//  m_regwrite   in   1   M-stage writes the GPR file
//  m_tnew       in   2   M-stage cycles until result is available (0..1)
//  e_md_start   in   1   E-stage instr issues to mult/div this cycle
//  e_md_div     in   1   qualifies e_md_start: 1 = div, 0 = mult
//  stall_f      out  1   hold PC
//  stall_d      out  1   hold F/D register
//  flush_e      out  1   load bubble (all-zero control) into D/E register
//  md_busy      out  1   mult/div timer nonzero (registered)
//  stall_cnt    out  32  saturating count of cycles with stall_d = 1
// BEHAVIOUR
//  Reset (reset=1 at posedge): md timer <= 0, stall_cnt <= 0. While reset is
//   high, stall_f/stall_d/flush_e are forced 0. md_busy = 0 after reset.
//  Data hazard, per source s in {rs,rt}, per producer X in {E,M}:
//   hz = (src_s != 0) && X_regwrite && (X_regaddr == src_s) && (tuse_s < X_tnew).
//   tuse = 3 never stalls. Register 0 never stalls.
//  MD hazard: md_hz = d_md_use && (e_md_start || md_busy).
//  stall = |hz | md_hz. stall_f = stall_d = flush_e = stall (combinational, same cycle).
//   E/M/W registers are never held by this block.
//  MD timer (count, CNT_W bits):
//   - e_md_start at posedge: count <= e_md_div ? DIV_CYCLES : MULT_CYCLES.
//   - else if count != 0: count <= count - 1.  Never wraps below 0.
//   - md_busy = (count != 0). Issue in cycle T -> md_busy high T+1..T+N.
//   - e_md_start while count != 0 (not legal via this block's stall, but
//     tolerated): timer reloads; latest issue wins.
//  stall_cnt: increments by 1 on each posedge with stall_d = 1 and reset = 0;
//   holds at 32'hFFFF_FFFF (no wrap).
//  Reset mid-operation: timer and counter cleared on that edge; no residual stall.
//  Outputs are glitch-tolerant combinational; no latency beyond the stated
//   same-cycle stall and registered md_busy.
// TESTING
//  1 lw $1 in E (e_regaddr=1,e_regwrite=1,e_tnew=2), D beq rs=1 tuse=0
//    -> stall_f=stall_d=flush_e=1; same in M with m_tnew=1 -> stall=1; m_tnew=0 -> 0.
//  2 Producer e_regaddr=0, e_tnew=2, d_rs=0 tuse=0 -> stall=0; d_tuse_rs=3, rs match -> stall=0.
//  3 e_md_start=1,e_md_div=0 at T, D mflo at T..T+6 -> stall 1 at T..T+5, 0 at T+6;
//    md_busy 1 exactly T+1..T+5.
//  4 Div issue (e_md_div=1) -> md_busy high 10 cycles; assert reset at busy cycle 4
//    -> next cycle md_busy=0, stall=0, stall_cnt=0.
//  5 Mult issue at T, second start at T+2 with e_md_div=1 -> timer reloads 10,
//    md_busy stays high through T+12.
//  6 Hold stall 6 cycles -> stall_cnt=6; preload near-max via force to FFFF_FFFE,
//    3 stall cycles -> stall_cnt = FFFF_FFFF held.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: D/E/M stage operand and producer info in,
// pipeline hold/bubble controls and mult/div status out.
interface hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_md_use;
  logic [4:0]  e_regaddr;
  logic        e_regwrite;
  logic [1:0]  e_tnew;
  logic [4:0]  m_regaddr;
  logic        m_regwrite;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        stall_f;
  logic        stall_d;
  logic        flush_e;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_use,
    output e_regaddr, e_regwrite, e_tnew,
    output m_regaddr, m_regwrite, m_tnew,
    output e_md_start, e_md_div,
    input  stall_f, stall_d, flush_e, md_busy, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_use,
    input  e_regaddr, e_regwrite, e_tnew,
    input  m_regaddr, m_regwrite, m_tnew,
    input  e_md_start, e_md_div,
    output stall_f, stall_d, flush_e, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller: Tuse/Tnew data hazards, mult/div busy timer
// and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic        clk,
  input logic        reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             md_busy;
  logic             data_hz;
  logic             md_hz;
  logic             stall;

  function automatic logic src_hz(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] addr,
    input logic       we,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && we && (addr == src) && (tuse < tnew);
  endfunction

  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    data_hz = 1'b0;
    data_hz |= src_hz(hz.d_rs, hz.d_tuse_rs,
                      hz.e_regaddr, hz.e_regwrite, hz.e_tnew);
    data_hz |= src_hz(hz.d_rs, hz.d_tuse_rs,
                      hz.m_regaddr, hz.m_regwrite, hz.m_tnew);
    data_hz |= src_hz(hz.d_rt, hz.d_tuse_rt,
                      hz.e_regaddr, hz.e_regwrite, hz.e_tnew);
    data_hz |= src_hz(hz.d_rt, hz.d_tuse_rt,
                      hz.m_regaddr, hz.m_regwrite, hz.m_tnew);
  end

  assign md_hz = hz.d_md_use && (hz.e_md_start || md_busy);
  assign stall = !reset && (data_hz || md_hz);

  // A new issue always reloads, so the latest mult/div wins.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.e_md_start) begin
      md_cnt_d = hz.e_md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_f   = stall;
  assign hz.stall_d   = stall;
  assign hz.flush_e   = stall;
  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-indexed reference model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  int     cyc    = 0;
  int     busy_end = -1;
  longint m_cnt  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_stall();
    logic [4:0] src[2];
    int         tu[2];
    logic [4:0] pa[2];
    logic       pw[2];
    int         pt[2];
    logic       s;
    if (reset) return 1'b0;
    src[0] = hif.d_rs;  tu[0] = int'(hif.d_tuse_rs);
    src[1] = hif.d_rt;  tu[1] = int'(hif.d_tuse_rt);
    pa[0] = hif.e_regaddr; pw[0] = hif.e_regwrite;
    pt[0] = int'(hif.e_tnew);
    pa[1] = hif.m_regaddr; pw[1] = hif.m_regwrite;
    pt[1] = int'(hif.m_tnew);
    s = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (src[i] != 0 && pw[j] && pa[j] == src[i] && tu[i] < pt[j])
          s = 1'b1;
    if (hif.d_md_use && (hif.e_md_start || cyc <= busy_end))
      s = 1'b1;
    return s;
  endfunction

  task automatic idle();
    hif.d_rs = 0; hif.d_rt = 0;
    hif.d_tuse_rs = 3; hif.d_tuse_rt = 3;
    hif.d_md_use = 0;
    hif.e_regaddr = 0; hif.e_regwrite = 0; hif.e_tnew = 0;
    hif.m_regaddr = 0; hif.m_regwrite = 0; hif.m_tnew = 0;
    hif.e_md_start = 0; hif.e_md_div = 0;
    reset = 0;
  endtask

  // Called at a negedge with inputs applied: check, clock, advance model.
  task automatic step();
    logic s;
    #1;
    s = exp_stall();
    chk("stall_f", 32'(hif.stall_f), 32'(s));
    chk("stall_d", 32'(hif.stall_d), 32'(s));
    chk("flush_e", 32'(hif.flush_e), 32'(s));
    chk("md_busy", 32'(hif.md_busy), 32'(cyc <= busy_end));
    chk("stall_cnt", hif.stall_cnt, 32'(m_cnt));
    @(posedge clk);
    if (reset) begin
      busy_end = -1;
      m_cnt = 0;
    end else begin
      if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (hif.e_md_start)
        busy_end = cyc + (hif.e_md_div ? 10 : 5);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state check with reset still high
    step();
    idle();
    step();

    // 1: load-use against E, then M
    hif.e_regaddr = 1; hif.e_regwrite = 1; hif.e_tnew = 2;
    hif.d_rs = 1; hif.d_tuse_rs = 0;
    chk("t1_e_stall", 32'(exp_stall()), 32'd1);
    step();
    idle();
    hif.m_regaddr = 1; hif.m_regwrite = 1; hif.m_tnew = 1;
    hif.d_rs = 1; hif.d_tuse_rs = 0;
    step();
    hif.m_tnew = 0;
    step();

    // 2: register zero and unused source never stall
    idle();
    hif.e_regaddr = 0; hif.e_regwrite = 1; hif.e_tnew = 2;
    hif.d_rs = 0; hif.d_tuse_rs = 0;
    step();
    hif.e_regaddr = 7; hif.d_rs = 7; hif.d_tuse_rs = 3;
    step();
    hif.d_rt = 7; hif.d_tuse_rt = 1;
    step();

    // 3: mult issue with mflo waiting in D
    idle();
    hif.d_md_use = 1; hif.e_md_start = 1;
    step();
    hif.e_md_start = 0;
    for (int k = 1; k <= 6; k++) begin
      chk("t3_busy_win", 32'(hif.md_busy), 32'(k >= 2 && k <= 5 ? 1 : (k == 1)));
      step();
    end

    // 4: div issue, reset mid-busy
    idle();
    hif.e_md_start = 1; hif.e_md_div = 1;
    step();
    idle();
    hif.d_md_use = 1;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    step();
    chk("t4_cnt_clr", hif.stall_cnt, 32'd0);

    // 5: mult then div reload
    idle();
    hif.e_md_start = 1;
    step();
    hif.e_md_start = 0;
    step();
    hif.e_md_start = 1; hif.e_md_div = 1;
    step();
    idle();
    repeat (11) step();

    // 6: stall counter and saturation
    idle();
    reset = 1;
    step();
    idle();
    hif.d_rs = 4; hif.d_tuse_rs = 0;
    hif.e_regaddr = 4; hif.e_regwrite = 1; hif.e_tnew = 1;
    repeat (6) step();
    chk("t6_cnt6", hif.stall_cnt, 32'd6);
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    hif.d_rs = 4; hif.d_tuse_rs = 0;
    hif.e_regaddr = 4; hif.e_regwrite = 1; hif.e_tnew = 1;
    repeat (3) step();
    chk("t6_sat", hif.stall_cnt, 32'hFFFF_FFFF);
    step();

    // random traffic
    idle();
    reset = 1;
    step();
    for (int n = 0; n < 600; n++) begin
      hif.d_rs       = 5'($urandom_range(0, 3));
      hif.d_rt       = 5'($urandom_range(0, 3));
      hif.d_tuse_rs  = 2'($urandom_range(0, 3));
      hif.d_tuse_rt  = 2'($urandom_range(0, 3));
      hif.d_md_use   = ($urandom_range(0, 2) == 0);
      hif.e_regaddr  = 5'($urandom_range(0, 3));
      hif.e_regwrite = 1'($urandom);
      hif.e_tnew     = 2'($urandom_range(0, 2));
      hif.m_regaddr  = 5'($urandom_range(0, 3));
      hif.m_regwrite = 1'($urandom);
      hif.m_tnew     = 2'($urandom_range(0, 1));
      hif.e_md_start = ($urandom_range(0, 7) == 0);
      hif.e_md_div   = 1'($urandom);
      reset          = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
